// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: first-word-fall-through read port, sticky overrun and level IRQ.
// Optional idle-timeout IRQ is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned THRESHOLD      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 208320
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic                    ovr_clr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overrun,
  output logic                    irq_level,
  output logic                    irq_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_bad_threshold
    $error("uart_rx_fifo: THRESHOLD must be in 1..DEPTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT_CYCLES must be >= 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  empty, full;
  logic                  pop_w, push_w, drop_w;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Flush overrides push/pop; a byte arriving on a flush cycle is silently discarded.
  assign pop_w  = ~flush & ~empty & out_ready;
  assign push_w = ~flush & in_valid & (~full | pop_w);
  assign drop_w = ~flush & in_valid & full & ~pop_w;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (drop_w)       overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign irq_level = (count_q >= PW'(THRESHOLD));

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q, idle_d;

  // Idle counter restarts on any activity or while empty, saturating at the limit.
  always_comb begin
    idle_d = idle_q;
    if (push_w || pop_w || flush || empty) idle_d = '0;
    else if (idle_q != TW'(TIMEOUT_CYCLES)) idle_d = idle_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign irq_timeout = (idle_q == TW'(TIMEOUT_CYCLES));
`else
  assign irq_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand sequences and random traffic vs. a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned THR   = 8;
  localparam int unsigned TO    = 10;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          ovr_clr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          irq_level;
  logic          irq_timeout;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(THR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .ovr_clr(ovr_clr), .count(count), .overrun(overrun),
    .irq_level(irq_level), .irq_timeout(irq_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue of bytes, a sticky flag and an idle-cycle count.
  byte unsigned mq[$];
  bit           m_ovr;
  int           m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_idle = 0;
  endfunction

  function automatic void model_edge();
    bit was_empty = (mq.size() == 0);
    bit is_full   = (mq.size() == DEPTH);
    bit p, u, d;
    if (flush) begin
      mq.delete();
      if (ovr_clr) m_ovr = 1'b0;
      m_idle = 0;
      return;
    end
    p = !was_empty && out_ready;
    u = in_valid && (!is_full || p);
    d = in_valid && is_full && !p;
    if (p) void'(mq.pop_front());
    if (u) mq.push_back(in_data);
    if (d) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    if (u || p || was_empty) m_idle = 0;
    else if (m_idle < int'(TO)) m_idle++;
  endfunction

  task automatic check_model(input string tag);
    int exp_data = (mq.size() != 0) ? int'(mq[0]) : 0;
    chk({tag, ".count"},       32'(count),       32'(mq.size()));
    chk({tag, ".out_valid"},   32'(out_valid),   32'(mq.size() != 0));
    chk({tag, ".out_data"},    32'(out_data),    32'(exp_data));
    chk({tag, ".overrun"},     32'(overrun),     32'(m_ovr));
    chk({tag, ".irq_level"},   32'(irq_level),   32'(mq.size() >= THR));
    chk({tag, ".irq_timeout"}, 32'(irq_timeout), 32'(TO_EN && m_idle == int'(TO)));
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit rdy, input bit fl, input bit oc);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    ovr_clr   = oc;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_model(tag);
  endtask

  typedef struct {
    bit          iv;
    logic [7:0]  d;
    bit          rdy;
    int          e_cnt;
    logic [7:0]  e_data;
    bit          e_valid;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 8'h11, 1'b1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 8'h11, 1'b1};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3, 8'h11, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 2, 8'h22, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 8'h33, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.overrun", 32'(overrun), 32'd0);
    chk("reset.irq_timeout", 32'(irq_timeout), 32'd0);
    rst_n = 1'b1;

    // Basic push then drain, table driven.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].rdy, 1'b0, 1'b0);
      tick("t1");
      chk($sformatf("t1[%0d].count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("t1[%0d].out_data", i), 32'(out_data), 32'(tbl[i].e_data));
      chk($sformatf("t1[%0d].out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
    end

    // Overflow by one: the 17th byte is dropped.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      tick("t2.fill");
    end
    chk("t2.count_full", 32'(count), 32'd16);
    chk("t2.overrun_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk($sformatf("t2.drain[%0d]", i), 32'(out_data), 32'(i));
      tick("t2.drain");
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick("t2.clr");
    chk("t2.overrun_clr", 32'(overrun), 32'd0);

    // Full with simultaneous push and pop: no overrun.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      tick("t3.fill");
    end
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    tick("t3.pushpop");
    chk("t3.overrun", 32'(overrun), 32'd0);
    chk("t3.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (i == 15) chk("t3.last", 32'(out_data), 32'hA5);
      tick("t3.drain");
    end

    // Level interrupt at THRESHOLD.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
      tick("t4.fill");
    end
    chk("t4.irq_below", 32'(irq_level), 32'd0);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    tick("t4.eighth");
    chk("t4.irq_at", 32'(irq_level), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick("t4.pop");
    chk("t4.irq_after_pop", 32'(irq_level), 32'd0);
    for (int i = 0; i < 7; i++) tick("t4.drain");

    // Idle timeout after a single byte.
    drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    tick("t5.push");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick("t5.idle");
      chk($sformatf("t5.timeout[%0d]", k), 32'(irq_timeout), 32'(TO_EN && k >= 10));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick("t5.pop");
    chk("t5.timeout_pop", 32'(irq_timeout), 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
      tick("t6.fill");
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.async_count", 32'(count), 32'd0);
    chk("t6.async_valid", 32'(out_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick("t6.push");
    chk("t6.data", 32'(out_data), 32'h5A);
    chk("t6.count", 32'(count), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick("t6.pop");

    // Flush with in_valid keeps the sticky overrun.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
      tick("t7.fill");
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick("t7.part");
    chk("t7.count4", 32'(count), 32'd4);
    drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    tick("t7.flush");
    chk("t7.count0", 32'(count), 32'd0);
    chk("t7.overrun_kept", 32'(overrun), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick("t7.clr");

    // Wrap: 40 push/pop pairs preserve order.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b0);
      if (i > 0) chk($sformatf("t7.wrap[%0d]", i), 32'(out_data), 32'(i));
      tick("t7.wrap");
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick("t7.wrap_end");
    chk("t7.wrap_empty", 32'(out_valid), 32'd0);

    // Random traffic with varying drain rates.
    for (int n = 0; n < 3000; n++) begin
      int rdy_pct = ((n / 200) % 3 == 0) ? 20 : (((n / 200) % 3 == 1) ? 50 : 90);
      drive($urandom_range(99) < 60, 8'($urandom),
            $urandom_range(99) < rdy_pct, $urandom_range(63) == 0, $urandom_range(15) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
